// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage request/response bundle for data_mem_responder
interface data_mem_responder_if;
  logic        req;
  logic [8:0]  A;
  logic [31:0] DI;
  logic [1:0]  Size;
  logic        RW;
  logic        SE;
  logic [31:0] DO;
  logic        ready;
  logic        busy;
  logic        err;
  modport master (output req, A, DI, Size, RW, SE, input DO, ready, busy, err);
  modport slave (input req, A, DI, Size, RW, SE, output DO, ready, busy, err);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated 512-byte big-endian data memory answering one MEM-stage request at a time
module data_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  data_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  a_q, a_d, a;
  logic [31:0] di_q, di_d, di;
  logic [1:0]  size_q, size_d, size;
  logic        rw_q, rw_d, rw;
  logic        se_q, se_d, se;
  logic [31:0] do_q, do_d;
  logic        err_q, err_d;
  logic        accept, go, bad, we;
  logic [7:0]  r0, r1, r2, r3;
  logic [31:0] ld;
  logic [7:0]  mem [512];
  always_comb begin
    accept = state_q == IDLE && bus.req;
    go = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd1);
    // with zero wait states the access happens on the accepting edge, straight from the bus
    a = state_q == IDLE ? bus.A : a_q;
    di = state_q == IDLE ? bus.DI : di_q;
    size = state_q == IDLE ? bus.Size : size_q;
    rw = state_q == IDLE ? bus.RW : rw_q;
    se = state_q == IDLE ? bus.SE : se_q;
    bad = size == 2'b11 || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
    we = go && rw && !bad && !reset;
    r0 = mem[a];
    r1 = mem[a | 9'd1];
    r2 = mem[a | 9'd2];
    r3 = mem[a | 9'd3];
    ld = size == 2'b00 ? {{24{se && r0[7]}}, r0} :
         size == 2'b01 ? {{16{se && r0[7]}}, r0, r1} : {r0, r1, r2, r3};
    state_d = accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) :
              state_q == WAIT ? (cnt_q == 4'd1 ? RESP : WAIT) : IDLE;
    cnt_d = accept ? 4'(WAIT_CYCLES) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    a_d = accept ? bus.A : a_q;
    di_d = accept ? bus.DI : di_q;
    size_d = accept ? bus.Size : size_q;
    rw_d = accept ? bus.RW : rw_q;
    se_d = accept ? bus.SE : se_q;
    do_d = go ? ((rw || bad) ? 32'd0 : ld) : do_q;
    err_d = go ? bad : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      a_q <= 9'd0;
      di_q <= 32'd0;
      size_q <= 2'd0;
      rw_q <= 1'b0;
      se_q <= 1'b0;
      do_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      di_q <= di_d;
      size_q <= size_d;
      rw_q <= rw_d;
      se_q <= se_d;
      do_q <= do_d;
      err_q <= err_d;
    end
  end
  // array is deliberately not reset; only addressed bytes of a legal store change
  always_ff @(posedge clk) begin
    if (we) begin
      if (size == 2'b00) begin
        mem[a] <= di[7:0];
      end else if (size == 2'b01) begin
        mem[a] <= di[15:8];
        mem[a | 9'd1] <= di[7:0];
      end else begin
        mem[a] <= di[31:24];
        mem[a | 9'd1] <= di[23:16];
        mem[a | 9'd2] <= di[15:8];
        mem[a | 9'd3] <= di[7:0];
      end
    end
  end
  assign bus.DO = do_q;
  assign bus.ready = state_q == RESP;
  assign bus.busy = state_q != IDLE;
  assign bus.err = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a byte-array model
module tb_data_mem_responder;
  localparam int W2 = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [512];
  data_mem_responder_if b2();
  data_mem_responder_if b0();
  data_mem_responder #(.WAIT_CYCLES(W2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  data_mem_responder #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [8:0] addr, input logic [31:0] di, input logic [1:0] sz,
                    input logic rw, input logic se, input string tag, output logic [31:0] dout);
    int n, k;
    logic bad;
    logic [31:0] v, exp_do;
    n = 1 << sz;
    bad = sz == 2'd3 || (int'(addr) % n) != 0;
    v = 0;
    if (!bad) for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl[int'(addr) + i]);
    if (!bad && se && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
    exp_do = (bad || rw) ? 32'd0 : v;
    @(negedge clk);
    b2.A = addr; b2.DI = di; b2.Size = sz; b2.RW = rw; b2.SE = se; b2.req = 1'b1;
    @(negedge clk);
    b2.req = 1'b0;
    b2.A = 9'($urandom); b2.DI = $urandom; b2.Size = 2'($urandom); b2.RW = 1'($urandom); b2.SE = 1'($urandom);
    k = 1;
    chk({tag, "_busy"}, 32'(b2.busy), 32'd1);
    while (!b2.ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(W2 + 1));
    chk({tag, "_do"}, b2.DO, exp_do);
    chk({tag, "_err"}, 32'(b2.err), 32'(bad));
    dout = b2.DO;
    @(negedge clk);
    chk({tag, "_rdy_drop"}, 32'(b2.ready), 32'd0);
    chk({tag, "_do_hold"}, b2.DO, exp_do);
    if (!bad && rw) for (int i = 0; i < n; i++) mdl[int'(addr) + i] = 8'(di >> (8*(n-1-i)));
  endtask

  initial begin
    logic [31:0] d;
    logic [8:0] ad;
    logic [1:0] sz;
    int last, pulses, seen;
    b2.req = 0; b2.A = 0; b2.DI = 0; b2.Size = 0; b2.RW = 0; b2.SE = 0;
    b0.req = 0; b0.A = 0; b0.DI = 0; b0.Size = 0; b0.RW = 0; b0.SE = 0;
    repeat (3) @(negedge clk);
    chk("rst_do", b2.DO, 32'd0);
    chk("rst_ready", 32'(b2.ready), 32'd0);
    chk("rst_busy", 32'(b2.busy), 32'd0);
    chk("rst_err", 32'(b2.err), 32'd0);
    chk("rst0_busy", 32'(b0.busy), 32'd0);
    reset = 1'b0;
    for (int w = 0; w < 128; w++) op(9'(w * 4), $urandom, 2'd2, 1'b1, 1'b0, "init", d);
    op(9'h010, 32'hDEADBEEF, 2'd2, 1'b1, 1'b0, "st_w", d);
    op(9'h010, 32'h0, 2'd2, 1'b0, 1'b0, "ld_w", d);
    chk("ld_w_const", d, 32'hDEADBEEF);
    op(9'h011, 32'h0, 2'd0, 1'b0, 1'b1, "ld_b_se", d);
    chk("ld_b_se_const", d, 32'hFFFFFFAD);
    op(9'h011, 32'h0, 2'd0, 1'b0, 1'b0, "ld_b_ze", d);
    chk("ld_b_ze_const", d, 32'h000000AD);
    op(9'h012, 32'h0, 2'd1, 1'b0, 1'b1, "ld_h_se", d);
    chk("ld_h_se_const", d, 32'hFFFFBEEF);
    op(9'h013, 32'h00000055, 2'd0, 1'b1, 1'b0, "st_b", d);
    op(9'h010, 32'h0, 2'd2, 1'b0, 1'b1, "ld_w2", d);
    chk("ld_w2_const", d, 32'hDEADBE55);
    op(9'h011, 32'h0, 2'd2, 1'b0, 1'b0, "mis_w", d);
    op(9'h010, 32'hFFFFFFFF, 2'd3, 1'b1, 1'b0, "sz11", d);
    op(9'h013, 32'hFFFFFFFF, 2'd1, 1'b1, 1'b0, "mis_h_st", d);
    op(9'h010, 32'h0, 2'd2, 1'b0, 1'b0, "ld_w3", d);
    chk("ld_w3_const", d, 32'hDEADBE55);
    for (int dly = 1; dly <= 2; dly++) begin
      @(negedge clk);
      b2.A = 9'h020; b2.DI = 32'h12345678; b2.Size = 2'd2; b2.RW = 1'b1; b2.req = 1'b1;
      @(negedge clk);
      b2.req = 1'b0;
      if (dly == 2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 32'(b2.busy), 32'd0);
      chk("abort_ready", 32'(b2.ready), 32'd0);
      chk("abort_do", b2.DO, 32'd0);
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (b2.ready) seen++;
      end
      chk("abort_no_ready", 32'(seen), 32'd0);
      op(9'h020, 32'h0, 2'd2, 1'b0, 1'b0, "abort_ld", d);
    end
    @(negedge clk);
    b2.A = 9'h020; b2.Size = 2'd2; b2.RW = 1'b1; b2.req = 1'b1; reset = 1'b1;
    @(negedge clk);
    b2.req = 1'b0; reset = 1'b0;
    chk("prio_busy", 32'(b2.busy), 32'd0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (b2.ready) seen++;
    end
    chk("prio_no_ready", 32'(seen), 32'd0);
    @(negedge clk);
    b2.A = 9'h010; b2.Size = 2'd2; b2.RW = 1'b0; b2.SE = 1'b0; b2.req = 1'b1;
    last = -1; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b2.ready) begin
        if (last >= 0) chk("held_gap", 32'(k - last), 32'(W2 + 2));
        else chk("held_first", 32'(k), 32'(W2 + 1));
        last = k;
        pulses++;
      end
    end
    b2.req = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd5);
    repeat (6) @(negedge clk);
    chk("held_idle", 32'(b2.busy), 32'd0);
    for (int t = 0; t < 80; t++) begin
      sz = 2'($urandom_range(0, 3));
      ad = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) ad = ad & ~9'((1 << sz) - 1);
      op(ad, $urandom, sz, 1'($urandom), 1'($urandom), "rnd", d);
    end
    @(negedge clk);
    b0.A = 9'h040; b0.DI = 32'hCAFEF00D; b0.Size = 2'd2; b0.RW = 1'b1; b0.SE = 1'b0; b0.req = 1'b1;
    @(negedge clk);
    b0.req = 1'b0; b0.DI = 32'h0;
    chk("w0_st_ready", 32'(b0.ready), 32'd1);
    chk("w0_st_err", 32'(b0.err), 32'd0);
    chk("w0_st_do", b0.DO, 32'd0);
    @(negedge clk);
    chk("w0_st_drop", 32'(b0.ready), 32'd0);
    b0.A = 9'h040; b0.RW = 1'b0; b0.req = 1'b1;
    @(negedge clk);
    b0.req = 1'b0;
    chk("w0_ld_ready", 32'(b0.ready), 32'd1);
    chk("w0_ld_do", b0.DO, 32'hCAFEF00D);
    @(negedge clk);
    b0.A = 9'h041; b0.Size = 2'd0; b0.SE = 1'b1; b0.req = 1'b1;
    @(negedge clk);
    b0.req = 1'b0;
    chk("w0_ldb_do", b0.DO, 32'hFFFFFFFE);
    @(negedge clk);
    b0.A = 9'h040; b0.Size = 2'd2; b0.req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("w0_held", 32'(b0.ready), 32'(k % 2));
    end
    b0.req = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
